i2c_rb_client: RTL and testbench
================================

# i2c_rb_client

Parametrised I2C target that bridges an external I2C controller to the on-chip register bank (`rb_*`) in the control top. It replaces the fixed 6-bit/single-byte I2C interface with configurable device address, register-address width and input glitch filtering. It adds auto-incrementing burst writes and reads, repeated-start register reads, and an explicit read strobe toward the bank. It sits between the board I2C pins and the register bank, one instance per bank.

## Interface
- `DEV_ADDR`, default 7'h48: 7-bit I2C target address.
- `ADDR_W`, default 6: register-address width (1..8); the pointer wraps at 2^ADDR_W.
- `FILTER_LEN`, default 3: number of consecutive equal synchronised samples required before SCL/SDA change is accepted (1..7).
- `clk` input 1: system clock; all logic on rising edge; must be ≥ 20× SCL frequency.
- `reset` input 1: asynchronous, active-high reset.
- `scl_i` input 1: raw I2C clock pin (asynchronous).
- `sda_i` input 1: raw I2C data pin (asynchronous).
- `sda_oe` output 1: 1 = pull SDA low (open-drain); 0 = release.
- `address` output ADDR_W: register pointer to the bank.
- `data_write` output 8: write data to the bank, valid while `write_en` is high.
- `write_en` output 1: one-cycle write strobe.
- `read_en` output 1: one-cycle read strobe; the bank presents `data_read` on the next cycle.
- `data_read` input 8: read data from the bank.
- `busy` output 1: high from an addressed START to STOP or a mismatched address.

## Operation
- Reset values: `sda_oe`=0, `address`=0, `data_write`=0, `write_en`=0, `read_en`=0, `busy`=0, FSM=IDLE. Reset releases SDA immediately because it is asynchronous.
- Input path: 2-flop synchroniser on each pin, then a FILTER_LEN stable-count filter. Edge detection runs on the filtered signals only.
- START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high. Both are honoured in every state.
  - START (including repeated START) goes to DEV.
  - STOP goes to IDLE and clears `busy`.
- FSM states: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WACK, RLOAD, RDATA, RACK, WAIT_STOP.
- Bits are sampled on SCL rising edges, MSB first.
- DEV: receives 8 bits.
  - If the upper 7 bits ≠ DEV_ADDR: go to WAIT_STOP, never drive SDA, `busy` stays 0.
  - If they match: go to DEV_ACK and set `busy`=1. The R/W bit selects REG (W) or RLOAD (R).
- REG: receives 8 bits. `address` ← low ADDR_W bits; upper bits are ignored. ACK, then WDATA.
- WDATA: receives 8 bits, then goes to WACK.
  - `data_write` ← byte and `write_en` pulses for one cycle, 1 cycle after the SCL rising edge of bit 0.
  - Target ACKs, then `address` increments (mod 2^ADDR_W) and the FSM returns to WDATA.
- RLOAD: `read_en` pulses at the current `address`. The next cycle captures `data_read` into the shift register, then the FSM enters RDATA.
- RDATA: shifts out 8 bits, then goes to RACK.
  - `sda_oe` = !bit; it changes only while SCL is low.
  - `address` increments after the 8th bit is shifted out.
- RACK: sample the controller's ACK.
  - ACK (0): go to RLOAD for the next byte.
  - NACK (1): go to WAIT_STOP.
- WAIT_STOP: SDA released; leaves only on STOP or START.
- Reads never pulse `write_en`, and writes never pulse `read_en`.

## Timing
- Input latency: 2 sync cycles + FILTER_LEN cycles from pin to filtered edge.
- `sda_oe` updates within 1 cycle of a filtered SCL falling edge. It never changes while filtered SCL is high, except when released by reset.
- ACK drive: `sda_oe`=1 from the SCL falling edge after bit 0 until the next SCL falling edge.
- `read_en` fires at the filtered SCL falling edge that ends the preceding ACK. The shift-register MSB reaches `sda_oe` 2 cycles later.
- START/STOP detection takes priority over bit sampling in the same cycle.
- Reset mid-transaction: the FSM returns to IDLE and no strobe is issued for the partial byte. The next transfer requires a fresh START.

## Test plan
- Single write: START, 0x90, 0x05, 0xA5, STOP → one `write_en` with `address`=5, `data_write`=0xA5. ACK on all 3 bytes; `busy` goes 1 then 0.
- Burst write with wrap (ADDR_W=6): reg 0x3E, data 0x11, 0x22, 0x33 → writes at 0x3E, 0x3F, 0x00 with `address` wrapping to 0.
- Repeated-start read: 0x90, 0x10, Sr, 0x91, bank returns 0x10+addr; controller ACK, ACK, NACK.
  - Bytes 0x20, 0x21, 0x22 appear on SDA.
  - Exactly 3 `read_en` pulses.
  - No `write_en`.
- Wrong address: 0x92 + data → SDA never driven, no strobes, `busy`=0, next valid transfer works.
- Glitch rejection (FILTER_LEN=3): a 2-cycle SCL low pulse and a 2-cycle SDA pulse while SCL is high → no bit shift and no START/STOP detected.
- Reset asserted after 4 data bits → `sda_oe`=0 in the same cycle, no `write_en`, and the FSM returns to IDLE.

Source files
------------

// File: rtl/i2c_rb_client.sv
// i2c_rb_client: I2C target bridging an external controller to a register bank.
// Filtered pins, auto-increment bursts and repeated-start reads.
module i2c_rb_client #(
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter int         ADDR_W     = 6,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_write,
  output logic              write_en,
  output logic              read_en,
  input  logic [7:0]        data_read,
  output logic              busy
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    REG,
    REG_ACK,
    WDATA,
    WACK,
    RLOAD,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

  state_t state;

  // Bit 0 carries SCL, bit 1 carries SDA through sync and filter.
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      filt;
  logic [1:0]      prev;
  logic [1:0][2:0] cnt;

  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       phase;
  logic       rw;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = filt[0] & ~prev[0];
  assign scl_fall  = ~filt[0] & prev[0];
  assign start_det = filt[0] & prev[0] & prev[1] & ~filt[1];
  assign stop_det  = filt[0] & prev[0] & ~prev[1] & filt[1];
  assign rx_byte   = {shreg[6:0], filt[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 2'b11;
      s2   <= 2'b11;
      filt <= 2'b11;
      prev <= 2'b11;
      cnt  <= '0;
    end else begin
      s1   <= {sda_i, scl_i};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      phase      <= 1'b0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      address    <= '0;
      data_write <= '0;
      write_en   <= 1'b0;
      read_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      write_en <= 1'b0;
      read_en  <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        phase  <= 1'b0;
      end else if (start_det) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        phase   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: ;
          DEV: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state <= DEV_ACK;
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                end else begin
                  state <= WAIT_STOP;
                  busy  <= 1'b0;
                end
              end
            end
          end
          REG, WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == REG) begin
                  address <= rx_byte[ADDR_W-1:0];
                  state   <= REG_ACK;
                end else begin
                  data_write <= rx_byte;
                  write_en   <= 1'b1;
                  state      <= WACK;
                end
              end
            end
          end
          // First SCL fall starts the ACK, the second ends it.
          DEV_ACK, REG_ACK, WACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase  <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == DEV_ACK && rw) begin
                  state   <= RLOAD;
                  read_en <= 1'b1;
                end else if (state == DEV_ACK) begin
                  state <= REG;
                end else begin
                  state <= WDATA;
                  if (state == WACK) address <= address + ADDR_W'(1);
                end
              end
            end
          end
          // One wait cycle lets the bank answer the read strobe.
          RLOAD: begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase   <= 1'b0;
              shreg   <= data_read;
              sda_oe  <= ~data_read[7];
              bit_cnt <= '0;
              state   <= RDATA;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                address <= address + ADDR_W'(1);
                phase   <= 1'b0;
                state   <= RACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (filt[1]) state <= WAIT_STOP;
              else phase <= 1'b1;
            end else if (scl_fall && phase) begin
              phase   <= 1'b0;
              read_en <= 1'b1;
              state   <= RLOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_rb_client.sv
// tb_i2c_rb_client: bit-banged I2C controller with a strobe scoreboard.
// Expected bank writes and reads are queued as each transfer is driven.
module tb_i2c_rb_client;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_c;
  logic       sda_c;
  logic       sda_line;
  logic       sda_oe;
  logic [5:0] address;
  logic [7:0] data_write;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_read = 8'h00;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [15:0] we;
  logic [7:0]  re;

  assign sda_line = sda_c & ~sda_oe;

  always #5 clk = ~clk;

  i2c_rb_client #(
    .DEV_ADDR  (7'h48),
    .ADDR_W    (6),
    .FILTER_LEN(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_c),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .address   (address),
    .data_write(data_write),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_read (data_read),
    .busy      (busy)
  );

  // Bank model: data appears the cycle after the read strobe.
  always @(posedge clk)
    if (read_en) data_read <= 8'h10 + {2'b00, address};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (write_en) begin
        wr_cnt++;
        check("wr_pending", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          check("wr_addr", 32'(address), 32'(we[13:8]));
          check("wr_data", 32'(data_write), 32'(we[7:0]));
        end
      end
      if (read_en) begin
        rd_cnt++;
        check("rd_pending", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          re = rq.pop_front();
          check("rd_addr", 32'(address), 32'(re));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // g=1: 2-cycle SCL low glitch, g=2: 2-cycle SDA glitch, both in SCL high.
  task automatic bit_xfer(input logic b, input int g, output logic s);
    sda_c = b;
    wait_clk(Q);
    scl_c = 1'b1;
    wait_clk(8);
    if (g == 1) begin
      scl_c = 1'b0;
      wait_clk(2);
      scl_c = 1'b1;
    end else if (g == 2) begin
      sda_c = ~b;
      wait_clk(2);
      sda_c = b;
    end
    wait_clk(Q);
    s = sda_line;
    wait_clk(4);
    scl_c = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_c = 1'b1;
    wait_clk(Q);
    scl_c = 1'b1;
    wait_clk(Q);
    sda_c = 1'b0;
    wait_clk(Q);
    scl_c = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0;
    wait_clk(Q);
    scl_c = 1'b1;
    wait_clk(Q);
    sda_c = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int gm,
                            output logic ack);
    logic s;
    int   g;
    for (int i = 7; i >= 0; i--) begin
      g = 0;
      if (gm != 0 && (i == 7 || i == 4)) g = 2;
      if (gm != 0 && i == 6) g = 1;
      bit_xfer(d[i], g, s);
    end
    bit_xfer(1'b1, 0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 0, s);
      d[i] = s;
    end
    bit_xfer(nack, 0, s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         oe0;
    int         wr0;
    int         rd0;

    reset = 1'b1;
    scl_c = 1'b1;
    sda_c = 1'b1;
    wait_clk(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_write", 32'(data_write), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_read_en", 32'(read_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clk(5);

    // Single write
    wq.push_back({2'b00, 6'h05, 8'hA5});
    i2c_start();
    write_byte(8'h90, 0, ack);
    check("w1_dev_ack", 32'(ack), 32'd0);
    check("w1_busy_on", 32'(busy), 32'd1);
    write_byte(8'h05, 0, ack);
    check("w1_reg_ack", 32'(ack), 32'd0);
    write_byte(8'hA5, 0, ack);
    check("w1_dat_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("w1_busy_off", 32'(busy), 32'd0);
    check("w1_wr_cnt", 32'(wr_cnt), 32'd1);

    // Burst write wrapping the pointer
    wq.push_back({2'b00, 6'h3E, 8'h11});
    wq.push_back({2'b00, 6'h3F, 8'h22});
    wq.push_back({2'b00, 6'h00, 8'h33});
    i2c_start();
    write_byte(8'h90, 0, ack);
    check("bw_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h3E, 0, ack);
    check("bw_reg_ack", 32'(ack), 32'd0);
    write_byte(8'h11, 0, ack);
    check("bw_d0_ack", 32'(ack), 32'd0);
    write_byte(8'h22, 0, ack);
    check("bw_d1_ack", 32'(ack), 32'd0);
    write_byte(8'h33, 0, ack);
    check("bw_d2_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("bw_wr_cnt", 32'(wr_cnt), 32'd4);
    check("bw_addr_post", 32'(address), 32'h01);

    // Repeated-start read of three bytes
    rq.push_back(8'h10);
    rq.push_back(8'h11);
    rq.push_back(8'h12);
    i2c_start();
    write_byte(8'h90, 0, ack);
    check("rd_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h10, 0, ack);
    check("rd_reg_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h91, 0, ack);
    check("rd_devr_ack", 32'(ack), 32'd0);
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'h20);
    read_byte(1'b0, d);
    check("rd_byte1", 32'(d), 32'h21);
    read_byte(1'b1, d);
    check("rd_byte2", 32'(d), 32'h22);
    i2c_stop();
    wait_clk(10);
    check("rd_rd_cnt", 32'(rd_cnt), 32'd3);
    check("rd_no_write", 32'(wr_cnt), 32'd4);
    check("rd_busy_off", 32'(busy), 32'd0);

    // Wrong device address
    oe0 = oe_cnt;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    busy_cnt = 0;
    i2c_start();
    write_byte(8'h92, 0, ack);
    check("na_dev_nack", 32'(ack), 32'd1);
    write_byte(8'h55, 0, ack);
    check("na_dat_nack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clk(10);
    check("na_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    check("na_busy_cycles", 32'(busy_cnt), 32'd0);
    check("na_wr", 32'(wr_cnt - wr0), 32'd0);
    check("na_rd", 32'(rd_cnt - rd0), 32'd0);

    wq.push_back({2'b00, 6'h07, 8'h5A});
    i2c_start();
    write_byte(8'h90, 0, ack);
    check("na2_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h07, 0, ack);
    write_byte(8'h5A, 0, ack);
    check("na2_dat_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("na2_wr_cnt", 32'(wr_cnt), 32'd5);

    // Glitches on SCL and SDA during a data byte
    wq.push_back({2'b00, 6'h20, 8'hA5});
    i2c_start();
    write_byte(8'h90, 0, ack);
    write_byte(8'h20, 0, ack);
    write_byte(8'hA5, 1, ack);
    check("gl_dat_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("gl_wr_cnt", 32'(wr_cnt), 32'd6);

    // Reset while the target drives an ACK
    i2c_start();
    d = 8'h90;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], 0, s);
    sda_c = 1'b1;
    wait_clk(Q);
    scl_c = 1'b1;
    wait_clk(6);
    check("ra_ack_drv", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("ra_async_oe", 32'(sda_oe), 32'd0);
    check("ra_async_busy", 32'(busy), 32'd0);
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);

    // Reset after four data bits
    i2c_start();
    write_byte(8'h90, 0, ack);
    write_byte(8'h07, 0, ack);
    check("rm_reg_ack", 32'(ack), 32'd0);
    d = 8'hC3;
    for (int i = 7; i >= 4; i--) bit_xfer(d[i], 0, s);
    reset = 1'b1;
    #1;
    check("rm_async_oe", 32'(sda_oe), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    sda_c = 1'b1;
    wait_clk(2);
    scl_c = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);
    check("rm_no_write", 32'(wr_cnt), 32'd6);

    // Without a fresh START the target stays silent
    write_byte(8'h90, 0, ack);
    check("ns_nack", 32'(ack), 32'd1);
    check("ns_busy", 32'(busy), 32'd0);
    i2c_stop();
    wait_clk(10);

    wq.push_back({2'b00, 6'h09, 8'h3C});
    i2c_start();
    write_byte(8'h90, 0, ack);
    check("ps_dev_ack", 32'(ack), 32'd0);
    write_byte(8'h09, 0, ack);
    write_byte(8'h3C, 0, ack);
    check("ps_dat_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(10);
    check("ps_wr_cnt", 32'(wr_cnt), 32'd7);
    check("ps_rd_cnt", 32'(rd_cnt), 32'd3);

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
